// File: rtl/ram_bridge_pkg.sv
// Shared definitions for the RAM request/response bridge: FSM state
// encodings, byte-enable constants and small decode helpers.
package ram_bridge_pkg;

    // Byte lane geometry of the 32-bit data path.
    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    // FSM state encodings.
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RMW_RD = 2'd2;
    localparam logic [1:0] RMW_WR = 2'd3;

    // Byte-enable patterns that do not need a read-modify-write.
    localparam logic [3:0] BE_FULL = 4'hF;
    localparam logic [3:0] BE_NONE = 4'h0;

    // A write touching some but not all lanes must merge with the old word.
    function automatic logic is_partial_write(input logic we, input logic [3:0] be);
        return we & (be != BE_FULL) & (be != BE_NONE);
    endfunction

endpackage

// File: rtl/ram_byte_merge.sv
// Combinational byte-lane mux used by the read-modify-write path: each lane
// takes the new byte when its enable is set, otherwise keeps the old byte.
// be[3] selects bits 31:24, be[0] selects bits 7:0.
// Only instantiated when RAM_BRIDGE_BYTE_WRITE_EN is defined.
module ram_byte_merge
    import ram_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] old_word,
    input  logic [DATA_WIDTH-1:0] new_word,
    input  logic [NUM_LANES-1:0]  be,
    output logic [DATA_WIDTH-1:0] merged_word
);

    // Select each byte lane from the new or the old word.
    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (be[i]) begin
                merged_word[LANE_W*i +: LANE_W] = new_word[LANE_W*i +: LANE_W];
            end else begin
                merged_word[LANE_W*i +: LANE_W] = old_word[LANE_W*i +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/ram_bus_bridge.sv
// Request/response front-end for a single-port 512x32 RAM with one-cycle
// registered read. One request is in flight at a time; every request gets a
// one-cycle rsp_valid strobe, with read data taken straight from the RAM.
//
// Optional feature macro: RAM_BRIDGE_BYTE_WRITE_EN
//   defined   - partial byte-enable writes run as read-modify-write
//               (RMW_RD then RMW_WR), acknowledged one cycle later.
//   undefined - any write with a non-zero byte enable writes the full word.
// In both builds a write with all byte enables clear never pulses ram_we but
// is still acknowledged.
module ram_bus_bridge
    import ram_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [3:0]            req_be,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    // FSM state and the latched request.
    logic [1:0]            state_q,     state_d;
    logic                  we_q,        we_d;
    logic [3:0]            be_q,        be_d;
    logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic                  rsp_valid_q, rsp_valid_d;

    logic                  accept_s;

`ifdef RAM_BRIDGE_BYTE_WRITE_EN
    // Old word arrives from the RAM in RMW_WR, one cycle after the RMW_RD read.
    logic [DATA_WIDTH-1:0] merged_s;

    ram_byte_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_byte_merge (
        .old_word    (ram_dout),
        .new_word    (wdata_q),
        .be          (be_q),
        .merged_word (merged_s)
    );
`endif

    // Ready only while idle, and never in a reset cycle so nothing is accepted
    // that the reset would immediately discard.
    always_comb begin
        req_ready = 1'b0;
        if (reset) begin
            req_ready = 1'b0;
        end else if (state_q == IDLE) begin
            req_ready = 1'b1;
        end else begin
            req_ready = 1'b0;
        end
    end

    assign accept_s = req_valid & req_ready;

    // Next-state logic: latch the request on transfer and sequence the RAM access.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        addr_d      = addr_q;
        rsp_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    we_d    = req_we;
                    be_d    = req_be;
                    wdata_d = req_wdata;
                    addr_d  = req_addr;
`ifdef RAM_BRIDGE_BYTE_WRITE_EN
                    if (is_partial_write(req_we, req_be)) begin
                        state_d = RMW_RD;
                    end else begin
                        state_d = ACCESS;
                    end
`else
                    state_d = ACCESS;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
            end
`ifdef RAM_BRIDGE_BYTE_WRITE_EN
            RMW_RD: begin
                state_d = RMW_WR;
            end
            RMW_WR: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM control: the write strobe is suppressed outright in a reset cycle so
    // an interrupted access cannot corrupt the target word.
    always_comb begin
        ram_we  = 1'b0;
        ram_din = {DATA_WIDTH{1'b0}};
        if (reset) begin
            ram_we  = 1'b0;
            ram_din = {DATA_WIDTH{1'b0}};
        end else begin
            case (state_q)
                ACCESS: begin
                    ram_we  = we_q & (be_q != BE_NONE);
                    ram_din = wdata_q;
                end
`ifdef RAM_BRIDGE_BYTE_WRITE_EN
                RMW_WR: begin
                    ram_we  = 1'b1;
                    ram_din = merged_s;
                end
`endif
                default: begin
                    ram_we  = 1'b0;
                    ram_din = {DATA_WIDTH{1'b0}};
                end
            endcase
        end
    end

    assign ram_addr  = addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = ram_dout;

    // State and request registers with synchronous reset; an in-flight
    // request is dropped without a response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            be_q        <= BE_NONE;
            wdata_q     <= {DATA_WIDTH{1'b0}};
            addr_q      <= {ADDR_WIDTH{1'b0}};
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

endmodule
